// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, digit limit, multiplier FSM state codes
// and a digit validity helper.
package bcd_pkg;

   localparam int unsigned BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   localparam int unsigned ST_W = 2;
   localparam logic [ST_W-1:0] IDLE = 2'd0;
   localparam logic [ST_W-1:0] CALC = 2'd1;
   localparam logic [ST_W-1:0] FIN  = 2'd2;

   function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
      return digit <= BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One decimal digit multiply-accumulate: a_d*m+cin split into a BCD digit and
// a decimal carry (max 9*9+8 = 89).
module bcd_digit_mac
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] a_d,
   input  logic [BCD_W-1:0] m,
   input  logic [BCD_W-1:0] cin,
   output logic [BCD_W-1:0] d,
   output logic [BCD_W-1:0] cout
);

   localparam int unsigned T_W = 7;

   logic [T_W-1:0] t;

   assign t    = T_W'(a_d) * T_W'(m) + T_W'(cin);
   assign d    = BCD_W'(t % T_W'(10));
   assign cout = BCD_W'(t / T_W'(10));

endmodule

// File: rtl/bcd_mul_digit_seq.sv
// Sequential packed-BCD operand times one BCD digit, one digit per clock LSD
// first, with start/busy/done handshake and invalid-digit flag.
module bcd_mul_digit_seq
   import bcd_pkg::*;
#(
   parameter int unsigned NDIG = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [BCD_W*NDIG-1:0]        a,
   input  logic [BCD_W-1:0]             m,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [BCD_W*(NDIG+1)-1:0]    p
);

   localparam int unsigned AW    = BCD_W * NDIG;
   localparam int unsigned PW    = BCD_W * (NDIG + 1);
   localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

   logic [ST_W-1:0]  state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [BCD_W-1:0] carry_q, carry_d;
   logic [AW-1:0]    opa_q, opa_d;
   logic [BCD_W-1:0] opm_q, opm_d;
   logic [PW-1:0]    p_q, p_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             in_ok;
   logic [BCD_W-1:0] mac_d, mac_cout;

   // Single MAC, time-multiplexed across operand digits by idx_q.
   bcd_digit_mac u_mac (
      .a_d  (opa_q[idx_q*BCD_W +: BCD_W]),
      .m    (opm_q),
      .cin  (carry_q),
      .d    (mac_d),
      .cout (mac_cout)
   );

   always_comb begin
      in_ok = is_bcd(m);
      for (int k = 0; k < int'(NDIG); k++) begin
         if (!is_bcd(a[k*BCD_W +: BCD_W])) in_ok = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      opa_d   = opa_q;
      opm_d   = opm_q;
      p_d     = p_q;
      err_d   = err_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               opa_d   = a;
               opm_d   = m;
               p_d     = '0;
               carry_d = '0;
               idx_d   = '0;
               busy_d  = 1'b1;
               err_d   = !in_ok;
               state_d = in_ok ? CALC : FIN;
            end
         end
         CALC: begin
            p_d[idx_q*BCD_W +: BCD_W] = mac_d;
            carry_d = mac_cout;
            idx_d   = IDX_W'(idx_q + 1'b1);
            if (idx_q == IDX_LAST) begin
               p_d[AW +: BCD_W] = mac_cout;
               idx_d   = '0;
               state_d = FIN;
            end
         end
         FIN: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= '0;
         opa_q   <= '0;
         opm_q   <= '0;
         p_q     <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         opa_q   <= opa_d;
         opm_q   <= opm_d;
         p_q     <= p_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;
   assign p    = p_q;

endmodule

// File: tb/tb_bcd_mul_digit_seq.sv
// Scoreboard bench for bcd_mul_digit_seq (NDIG=4): driver queues expected
// product/err/done-cycle, monitor checks every done pulse against the queue.
module tb_bcd_mul_digit_seq;

   localparam int unsigned NDIG = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [3:0]  m;
   logic        busy;
   logic        done;
   logic        err;
   logic [19:0] p;

   typedef struct {
      logic [19:0] p;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   bc;

   bcd_mul_digit_seq #(.NDIG(NDIG)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .m     (m),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .p     (p)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Accept one operation and queue its expected result and done cycle.
   task automatic issue(input logic [15:0] a_v, input logic [3:0] m_v,
                        input logic [19:0] exp_p, input logic exp_err);
      exp_t e;
      @(negedge clk);
      a = a_v;
      m = m_v;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("accept_busy", 32'(busy), 32'd1);
      e.p   = exp_p;
      e.err = exp_err;
      e.cyc = cyc + (exp_err ? 1 : int'(NDIG) + 1);
      sb.push_back(e);
   endtask

   task automatic wait_done(output int busy_cycles);
      int n = 0;
      busy_cycles = 1;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (busy === 1'b1) busy_cycles++;
      end
      if (done !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: got no done in %0d cycles, expected done", n);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
            end else begin
               e = sb.pop_front();
               check("product", 32'(p), 32'(e.p));
               check("err", 32'(err), 32'(e.err));
               check("latency", 32'(cyc), 32'(e.cyc));
               check("busy_at_done", 32'(busy), 32'd0);
            end
         end
      end
   end

   initial begin : driver
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      m     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_p", 32'(p), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      issue(16'h0123, 4'd5, 20'h00615, 1'b0);
      wait_done(bc);
      check("busy_cycles", 32'(bc), 32'd5);

      issue(16'h9999, 4'd9, 20'h89991, 1'b0);
      wait_done(bc);
      issue(16'h4567, 4'd0, 20'h00000, 1'b0);
      wait_done(bc);
      issue(16'h0000, 4'd9, 20'h00000, 1'b0);
      wait_done(bc);
      issue(16'h00A3, 4'd3, 20'h00000, 1'b1);
      wait_done(bc);
      issue(16'h0001, 4'hC, 20'h00000, 1'b1);
      wait_done(bc);
      issue(16'h1234, 4'd7, 20'h08638, 1'b0);
      wait_done(bc);
      check("err_hold", 32'(err), 32'd0);

      // Mid-CALC start and operand changes ignored, then held start re-accepts.
      issue(16'h0021, 4'd3, 20'h00063, 1'b0);
      @(negedge clk);
      @(negedge clk);
      a = 16'h9999;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 16'h0011;
      m = 4'd2;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("idle_gap_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check("b2b_accept", 32'(busy), 32'd1);
      start = 1'b0;
      begin
         exp_t e;
         e.p   = 20'h00022;
         e.err = 1'b0;
         e.cyc = cyc + int'(NDIG) + 1;
         sb.push_back(e);
      end
      wait_done(bc);

      // Reset mid-CALC aborts the op with no done pulse.
      issue(16'h0567, 4'd3, 20'h01701, 1'b0);
      void'(sb.pop_back());
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_err", 32'(err), 32'd0);
      check("abort_p", 32'(p), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      issue(16'h0002, 4'd4, 20'h00008, 1'b0);
      wait_done(bc);

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bcd_mul_digit_seq.md
Name: bcd_mul_digit_seq

Overview:
Sequential, parametrised BCD multiplier: an NDIG-digit packed-BCD operand times one BCD digit (0-9), producing an (NDIG+1)-digit packed-BCD product. Generalises the single-digit "times-5 to tens/units" conversion to any width and any multiplier digit. Processes one digit per clock, LSD first, with ripple decimal carry. Uses a start/busy/done handshake and flags invalid BCD input. Sits in the lab arithmetic datapath next to the other BCD converters and adders.

Parameters:
NDIG, 4, number of BCD digits in operand a (>=1)

Ports:
clk    input   1            system clock, rising-edge
rst    input   1            synchronous reset, active-high
start  input   1            request; sampled only in IDLE
a      input   4*NDIG       packed-BCD operand, digit k at a[4k+3:4k]
m      input   4            BCD multiplier digit
busy   output  1            operation in progress
done   output  1            one-cycle pulse, result valid
err    output  1            last operation had a non-BCD digit (>9) in a or m
p      output  4*(NDIG+1)   packed-BCD product, digit k at p[4k+3:4k]

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset (any state, incl. mid-operation): state=IDLE, busy=0, done=0, err=0, p=0, internal index/carry/latches=0. Aborted operation produces no done.
- States: IDLE, CALC, FIN.
- IDLE: start=1 at edge E -> latch a, m; clear p, carry=0, idx=0; check all digits.
  - all valid -> CALC, busy=1, err=0.
  - any digit >9 -> FIN, err=1, p stays 0, busy=1.
- CALC, each edge: t = a_lat[idx]*m_lat + carry (7-bit, max 9*9+8=89); p[idx] <= t mod 10; carry <= t div 10; idx++.
  - at idx=NDIG-1: also p[NDIG] <= t div 10; -> FIN.
- FIN: done=1 for exactly this one cycle, busy=0; next edge -> IDLE (done=0).
- Latency: valid operation, start sampled at edge E -> done high in cycle after edge E+NDIG+1; invalid -> done high in cycle after edge E+1.
- busy=1 from after edge E until the cycle done rises.
- p and err hold their values after done until the next accepted start (cleared at acceptance).
- start while in CALC/FIN ignored (no queuing); a/m changes after acceptance ignored.
- start held high continuously -> back-to-back operations, one IDLE cycle between them.
- m=0 or a=0 -> all-zero product, err=0, same latency.
- Product width NDIG+1 digits is exact: max 10^NDIG-1 times 9 fits; no overflow possible.

Decomposition:
- Package bcd_pkg: BCD_W=4, BCD_MAX=4'd9, state enum {IDLE,CALC,FIN}, function is_bcd(digit).
- Sub-module bcd_digit_mac (combinational): inputs a_d[3:0], m[3:0], cin[3:0]; outputs d[3:0], cout[3:0]; d=(a_d*m+cin)%10, cout=(a_d*m+cin)/10. Instantiated once, time-multiplexed by idx.

Test Plan:
- NDIG=4, a=16'h0123, m=5, start 1 cycle -> done after 5 edges, p=20'h00615, err=0, busy high for 5 cycles.
- a=16'h9999, m=9 -> p=20'h89991 (max carry chain), err=0.
- a=16'h4567, m=0 -> p=20'h00000; then a=16'h0000, m=9 -> p=0; err=0 both.
- a=16'h00A3, m=3 -> done after 2 edges, err=1, p=0; then a=16'h0001, m=4'hC -> err=1.
- Accept a=16'h0021, m=3; pulse start with a=16'h9999 mid-CALC -> ignored, result p=20'h00063; start held high -> second op accepted after one IDLE cycle.
- Assert rst during CALC -> next cycle busy=0, done=0, err=0, p=0, no done pulse; fresh op afterwards correct (0002*4 -> 00008).
